// File: rtl/fc1_activation_collector_if.sv
// ----------------------------------------------------------------------------
// fc1_activation_collector_if
// Activation stream from the fc1 activation collector to the fc2 stage.
//
// Handshake: a transfer happens on every rising clock edge where out_valid and
// out_ready are both 1. While out_valid=1 and out_ready=0 the source holds
// out_data and out_idx stable. out_valid never depends on out_ready.
//
// Signals
//   out_valid  source -> sink  out_data/out_idx carry a valid activation
//   out_ready  sink -> source  sink accepts the current activation
//   out_data   source -> sink  10-bit signed activation
//   out_idx    source -> sink  fc1 column index of out_data
//
// Modports: master = collector (source), slave = fc2 stage (sink).
// ----------------------------------------------------------------------------
interface fc1_activation_collector_if #(
    parameter int NUM_COL = 16
);
    localparam int IDX_W = $clog2(NUM_COL);

    logic             out_valid;
    logic             out_ready;
    logic [9:0]       out_data;
    logic [IDX_W-1:0] out_idx;

    modport master (
        output out_valid,
        output out_data,
        output out_idx,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_idx,
        output out_ready
    );
endinterface

// File: rtl/fc1_activation_collector.sv
// ----------------------------------------------------------------------------
// fc1_activation_collector
// Captures all NUM_COL fc1 column sums when the shared input counter reaches
// CAP_COUNT, converts each to a 10-bit activation (ReLU + saturation to 511),
// buffers them and streams them to fc2 one per handshake in column order.
//
// Build option: macro FC1_LEAKY_RELU_EN selects a leaky ReLU for negative sums
// ((s>>>3) saturated to -512). The port list is the same in both builds.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_count   shared fc1 input counter; capture when == CAP_COUNT
//   sum_vec    NUM_COL signed 25-bit sums, column k at [25k+24:25k]
//   out_if     activation stream (master side), see fc1_activation_collector_if
//   busy       1 while the buffer is draining
//   done       one-cycle pulse after the final activation is accepted
//   overrun    sticky, set when a capture arrives while draining (reset-only clear)
//   dbg_state  current FSM state encoding (IDLE=0, DRAIN=1, DONE=2)
// ----------------------------------------------------------------------------
module fc1_activation_collector #(
    parameter int NUM_COL   = 16,
    parameter int CAP_COUNT = 67
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [6:0]               in_count,
    input  logic [NUM_COL*25-1:0]    sum_vec,
    fc1_activation_collector_if.master out_if,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun,
    output logic [1:0]               dbg_state
);

    localparam int               IDX_W    = $clog2(NUM_COL);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COL - 1);
    localparam logic [6:0]       CAP_C    = 7'(CAP_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             overrun_q, overrun_d;
    logic [9:0]       buf_q [NUM_COL];
    logic [9:0]       buf_d [NUM_COL];

    logic cap;
    logic hs;
    logic load;

    // Column sum -> 10-bit signed activation.
    function automatic logic [9:0] activate(input logic signed [24:0] s);
        logic signed [24:0] sh;
        logic [9:0]         r;
        sh = s >>> 3;
        if (s > 25'sd511) begin
            r = 10'd511;
        end else if (s >= 25'sd0) begin
            r = s[9:0];
        end else begin
`ifdef FC1_LEAKY_RELU_EN
            if (sh < -25'sd512) r = 10'h200;
            else                r = sh[9:0];
`else
            r = 10'd0;
`endif
        end
        return r;
    endfunction

    assign cap = (in_count == CAP_C);
    assign hs  = (state_q == ST_DRAIN) && out_if.out_ready;

    // Next-state logic. A capture is accepted whenever the buffer is free or is
    // being freed by this very handshake; otherwise it is dropped and flagged.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;
        load      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cap) begin
                    load    = 1'b1;
                    state_d = ST_DRAIN;
                    idx_d   = '0;
                end
            end
            ST_DRAIN: begin
                if (hs && (idx_q == LAST_IDX)) begin
                    idx_d = '0;
                    if (cap) begin
                        // Back-to-back capture: skip DONE, start the new stream.
                        load    = 1'b1;
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    if (hs) idx_d = idx_q + IDX_W'(1);
                    if (cap) overrun_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (cap) begin
                    load    = 1'b1;
                    state_d = ST_DRAIN;
                    idx_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        for (int k = 0; k < NUM_COL; k++) begin
            buf_d[k] = buf_q[k];
            if (load) buf_d[k] = activate($signed(sum_vec[25*k +: 25]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
            for (int k = 0; k < NUM_COL; k++) buf_q[k] <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
            for (int k = 0; k < NUM_COL; k++) buf_q[k] <= buf_d[k];
        end
    end

    // All outputs come straight from registers so they settle to reset
    // values as soon as rst_n falls.
    assign out_if.out_valid = (state_q == ST_DRAIN);
    assign out_if.out_data  = (state_q == ST_DRAIN) ? buf_q[idx_q] : 10'd0;
    assign out_if.out_idx   = idx_q;
    assign busy             = (state_q == ST_DRAIN);
    assign done             = (state_q == ST_DONE);
    assign overrun          = overrun_q;
    assign dbg_state        = state_q;

endmodule
